// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding N byte requesters into one shared UART transmitter.
// Optional SEND watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NREQ           = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2:0]              cfg_baud,
    output logic [2:0]              baud_set,
    output logic [7:0]              tx_byte,
    output logic                    tx_send_en,
    input  logic                    tx_done,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int IDW = $clog2(NREQ);
    localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [IDW-1:0] IDX_LAST  = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            send_en_q, send_en_d;
    logic            busy_q, busy_d;
    logic [2:0]      baud_q, baud_d;
    logic            done_prev_q, done_prev_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

    logic            any_valid_s;
    logic            grant_s;
    logic [IDW-1:0]  winner_s;
    logic            done_rise_s;
    logic            timeout_hit_s;

    // First set bit at or after 'start', wrapping past the top index.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  start);
        logic [IDW-1:0] w;
        logic           found;
        int             idx;
        w     = start;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(start) + i) % NREQ;
            if (!found && v[idx]) begin
                w     = IDW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    assign any_valid_s = |req_valid;
    assign grant_s     = (state_q == ST_IDLE) && any_valid_s;
    assign winner_s    = rr_pick(req_valid, rr_q);
    // A tx_done already high at SEND entry has done_prev set, so it never counts.
    assign done_rise_s = tx_done && !done_prev_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_err_q, tmo_err_d;

    assign timeout_hit_s = (state_q == ST_SEND) && (tmo_cnt_q == TMO_LAST);

    // SEND-duration counter and sticky error flag.
    always_comb begin
        tmo_cnt_d = '0;
        tmo_err_d = tmo_err_q;
        if (state_q == ST_SEND) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end else begin
            tmo_cnt_d = '0;
        end
        if (grant_s) begin
            tmo_err_d = 1'b0;
        end else if (timeout_hit_s && !done_rise_s) begin
            tmo_err_d = 1'b1;
        end else begin
            tmo_err_d = tmo_err_q;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    logic tmo_cfg_unused_s;
    assign tmo_cfg_unused_s = (TIMEOUT_CYCLES > 0);
    assign timeout_hit_s    = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        req_ready_d = '0;
        tx_byte_d   = tx_byte_q;
        send_en_d   = send_en_q;
        baud_d      = baud_q;
        gap_cnt_d   = gap_cnt_q;
        done_prev_d = tx_done;
        case (state_q)
            ST_IDLE: begin
                baud_d = cfg_baud;
                if (any_valid_s) begin
                    state_d     = ST_SEND;
                    grant_d     = winner_s;
                    rr_d        = (winner_s == IDX_LAST) ? '0 : winner_s + IDW'(1);
                    req_ready_d = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
                    tx_byte_d   = req_data[{winner_s, 3'b000} +: 8];
                    send_en_d   = 1'b1;
                end else begin
                    send_en_d   = 1'b0;
                end
            end
            ST_SEND: begin
                if (done_rise_s || timeout_hit_s) begin
                    state_d   = ST_GAP;
                    send_en_d = 1'b0;
                    gap_cnt_d = '0;
                end else begin
                    send_en_d = 1'b1;
                end
            end
            ST_GAP: begin
                send_en_d = 1'b0;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                send_en_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            req_ready_q <= '0;
            tx_byte_q   <= 8'h00;
            send_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            baud_q      <= 3'b110;
            done_prev_q <= 1'b0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            req_ready_q <= req_ready_d;
            tx_byte_q   <= tx_byte_d;
            send_en_q   <= send_en_d;
            busy_q      <= busy_d;
            baud_q      <= baud_d;
            done_prev_q <= done_prev_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign tx_byte    = tx_byte_q;
    assign tx_send_en = send_en_q;
    assign grant_id   = grant_q;
    assign busy       = busy_q;
    assign baud_set   = baud_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, GAP_CYCLES=2, TIMEOUT_CYCLES=50).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [2:0]  cfg_baud;
    logic [2:0]  baud_set;
    logic [7:0]  tx_byte;
    logic        tx_send_en;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cfg_baud(cfg_baud), .baud_set(baud_set),
        .tx_byte(tx_byte), .tx_send_en(tx_send_en), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Completion pulse from SEND, then two GAP cycles, then IDLE.
    task automatic finish_send;
        tx_done = 1'b1;
        tick();
        n_vec++; if (tx_send_en !== 1'b0) begin n_err++; $error("FAIL gap1_send_en: %0h", tx_send_en); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $error("FAIL gap1_busy: %0h", busy); end
        tx_done = 1'b0;
        tick();
        n_vec++; if (tx_send_en !== 1'b0) begin n_err++; $error("FAIL gap2_send_en: %0h", tx_send_en); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $error("FAIL gap2_busy: %0h", busy); end
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $error("FAIL idle_busy: %0h", busy); end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_b [4];
        logic [3:0] exp_rdy;
        int         n_hi;
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst_n = 1'b1; req_valid = 4'b0000; req_data = 32'h0; cfg_baud = 3'b000; tx_done = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (tx_send_en !== 1'b0) begin n_err++; $error("FAIL rst_send_en: %0h", tx_send_en); end
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $error("FAIL rst_ready: %0h", req_ready); end
        n_vec++; if (tx_byte !== 8'h00) begin n_err++; $error("FAIL rst_tx_byte: %0h", tx_byte); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $error("FAIL rst_grant: %0h", grant_id); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $error("FAIL rst_busy: %0h", busy); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $error("FAIL rst_timeout: %0h", timeout_err); end
        n_vec++; if (baud_set !== 3'b110) begin n_err++; $error("FAIL rst_baud: %0h", baud_set); end
        tick();
        rst_n = 1'b1;
        tick();

        // Single requester 0 with 0x55.
        req_valid = 4'b0001; req_data = 32'h0000_0055;
        tick();
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $error("FAIL first_ready: %0h", req_ready); end
        n_vec++; if (tx_byte !== 8'h55) begin n_err++; $error("FAIL first_byte: %0h", tx_byte); end
        n_vec++; if (tx_send_en !== 1'b1) begin n_err++; $error("FAIL first_send_en: %0h", tx_send_en); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $error("FAIL first_grant: %0h", grant_id); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $error("FAIL first_busy: %0h", busy); end
        req_valid = 4'b0000; req_data = 32'h0000_00AA;
        tick();
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $error("FAIL first_ready_pulse: %0h", req_ready); end
        n_vec++; if (tx_byte !== 8'h55) begin n_err++; $error("FAIL first_byte_hold: %0h", tx_byte); end
        finish_send();

        // Reset mid-SEND of requester 2.
        req_valid = 4'b0100; req_data = 32'h0022_0000;
        tick();
        n_vec++; if (grant_id !== 2'd2) begin n_err++; $error("FAIL r2_grant: %0h", grant_id); end
        n_vec++; if (tx_byte !== 8'h22) begin n_err++; $error("FAIL r2_byte: %0h", tx_byte); end
        req_valid = 4'b0000;
        tick();
        rst_n = 1'b0;
        #1;
        n_vec++; if (tx_send_en !== 1'b0) begin n_err++; $error("FAIL midrst_send_en: %0h", tx_send_en); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $error("FAIL midrst_busy: %0h", busy); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $error("FAIL midrst_grant: %0h", grant_id); end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $error("FAIL postrst_ready: %0h", req_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $error("FAIL postrst_busy: %0h", busy); end

        // All four valid: grants 0,1,2,3, 5-cycle accept interval.
        req_valid = 4'b1111; req_data = 32'h4433_2211;
        for (int k = 0; k < 4; k++) begin
            exp_rdy = 4'b0001 << k;
            tick();
            n_vec++; if (grant_id !== 2'(k)) begin n_err++; $error("FAIL rr_grant: %0h", grant_id); end
            n_vec++; if (req_ready !== exp_rdy) begin n_err++; $error("FAIL rr_ready: %0h", req_ready); end
            n_vec++; if (tx_byte !== exp_b[k]) begin n_err++; $error("FAIL rr_byte: %0h", tx_byte); end
            n_vec++; if (tx_send_en !== 1'b1) begin n_err++; $error("FAIL rr_send_en: %0h", tx_send_en); end
            tick();
            n_vec++; if (req_ready !== 4'b0000) begin n_err++; $error("FAIL rr_ready_pulse: %0h", req_ready); end
            n_vec++; if (tx_send_en !== 1'b1) begin n_err++; $error("FAIL rr_send_en2: %0h", tx_send_en); end
            finish_send();
        end

        // Requester 0 drops valid as it would win; requester 1 takes it.
        req_valid = 4'b0010;
        tick();
        n_vec++; if (grant_id !== 2'd1) begin n_err++; $error("FAIL drop_grant: %0h", grant_id); end
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $error("FAIL drop_ready: %0h", req_ready); end
        req_valid = 4'b0000;
        tick();
        finish_send();

        // tx_done already high at grant is not completion.
        tx_done = 1'b1; req_valid = 4'b0001;
        tick();
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $error("FAIL held_grant: %0h", grant_id); end
        n_vec++; if (tx_send_en !== 1'b1) begin n_err++; $error("FAIL held_send_en0: %0h", tx_send_en); end
        req_valid = 4'b0000;
        tick();
        tick();
        n_vec++; if (tx_send_en !== 1'b1) begin n_err++; $error("FAIL held_send_en1: %0h", tx_send_en); end
        tx_done = 1'b0;
        tick();
        n_vec++; if (tx_send_en !== 1'b1) begin n_err++; $error("FAIL held_send_en2: %0h", tx_send_en); end
        finish_send();

        // Baud change during SEND deferred to IDLE.
        cfg_baud = 3'b100;
        tick();
        n_vec++; if (baud_set !== 3'b100) begin n_err++; $error("FAIL baud_idle: %0h", baud_set); end
        req_valid = 4'b1000;
        tick();
        n_vec++; if (grant_id !== 2'd3) begin n_err++; $error("FAIL baud_grant: %0h", grant_id); end
        cfg_baud = 3'b000; req_valid = 4'b0000;
        tick();
        n_vec++; if (baud_set !== 3'b100) begin n_err++; $error("FAIL baud_send: %0h", baud_set); end
        tx_done = 1'b1;
        tick();
        n_vec++; if (baud_set !== 3'b100) begin n_err++; $error("FAIL baud_gap1: %0h", baud_set); end
        tx_done = 1'b0;
        tick();
        n_vec++; if (baud_set !== 3'b100) begin n_err++; $error("FAIL baud_gap2: %0h", baud_set); end
        tick();
        tick();
        n_vec++; if (baud_set !== 3'b000) begin n_err++; $error("FAIL baud_after_idle: %0h", baud_set); end

        // SEND with tx_done tied low.
        req_valid = 4'b0100;
        tick();
        n_vec++; if (grant_id !== 2'd2) begin n_err++; $error("FAIL tmo_grant: %0h", grant_id); end
        req_valid = 4'b0000;
`ifdef UART_TX_ARB_TIMEOUT_EN
        n_hi = tx_send_en ? 1 : 0;
        for (int c = 0; c < 60 && tx_send_en; c++) begin
            tick();
            if (tx_send_en) n_hi++;
        end
        n_vec++; if (n_hi !== 50) begin n_err++; $error("FAIL tmo_send_cycles: %0d", n_hi); end
        n_vec++; if (tx_send_en !== 1'b0) begin n_err++; $error("FAIL tmo_send_en: %0h", tx_send_en); end
        n_vec++; if (timeout_err !== 1'b1) begin n_err++; $error("FAIL tmo_err_set: %0h", timeout_err); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $error("FAIL tmo_busy: %0h", busy); end
        tick();
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $error("FAIL tmo_idle_busy: %0h", busy); end
        n_vec++; if (timeout_err !== 1'b1) begin n_err++; $error("FAIL tmo_err_sticky: %0h", timeout_err); end
        req_valid = 4'b0001;
        tick();
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $error("FAIL tmo_next_grant: %0h", grant_id); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $error("FAIL tmo_err_clear: %0h", timeout_err); end
        req_valid = 4'b0000;
        finish_send();
`else
        n_hi = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (tx_send_en) n_hi++;
        end
        n_vec++; if (n_hi !== 60) begin n_err++; $error("FAIL notmo_send_cycles: %0d", n_hi); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $error("FAIL notmo_err: %0h", timeout_err); end
        finish_send();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
